// File: rtl/jt51_pg_pkg.sv
// Shared defaults and helpers for the phase generator accumulator.
package jt51_pg_pkg;
  localparam int SLOTS_DEF = 32;
  localparam int PHW_DEF   = 20;
  localparam int OUTW_DEF  = 10;
  localparam int MULW_DEF  = 4;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_HOLD = 2'd1,
    OP_LOAD = 2'd2,
    OP_CLR  = 2'd3
  } pg_op_t;

  function automatic int slot_w(input int slots);
    return (slots < 2) ? 1 : $clog2(slots);
  endfunction

  // Key-on clear beats preset, preset beats freeze.
  function automatic pg_op_t pg_op(input logic clr, input logic ld, input logic hd);
    if (clr) return OP_CLR;
    if (ld)  return OP_LOAD;
    if (hd)  return OP_HOLD;
    return OP_ADD;
  endfunction
endpackage

// File: rtl/jt51_pg_acc_if.sv
// Sample-side inputs and phase outputs of the accumulator.
interface jt51_pg_acc_if
  import jt51_pg_pkg::*;
#(
  parameter int SLOTS = SLOTS_DEF,
  parameter int PHW   = PHW_DEF,
  parameter int OUTW  = OUTW_DEF,
  parameter int MULW  = MULW_DEF
);
  localparam int SW = slot_w(SLOTS);

  logic            cen;
  logic            zero;
  logic [PHW-3:0]  base_in;
  logic [4:0]      dt_off;
  logic            dt_en;
  logic            dt_neg;
  logic [MULW-1:0] mul;
  logic            pg_rst;
  logic            hold;
  logic            load;
  logic [PHW-1:0]  load_val;
  logic [OUTW-1:0] phase_out;
  logic [PHW-1:0]  step_out;
  logic [SW-1:0]   slot_out;
  logic            valid;

  modport master (
    output cen, zero, base_in, dt_off, dt_en, dt_neg, mul,
           pg_rst, hold, load, load_val,
    input  phase_out, step_out, slot_out, valid
  );

  modport slave (
    input  cen, zero, base_in, dt_off, dt_en, dt_neg, mul,
           pg_rst, hold, load, load_val,
    output phase_out, step_out, slot_out, valid
  );
endinterface

// File: rtl/jt51_pg_step.sv
// Detune then frequency multiply; two registered stages, step valid 2 cen cycles after sampling.
module jt51_pg_step
  import jt51_pg_pkg::*;
#(
  parameter int PHW  = PHW_DEF,
  parameter int MULW = MULW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic [PHW-3:0]  base_in,
  input  logic [4:0]      dt_off,
  input  logic            dt_en,
  input  logic            dt_neg,
  input  logic [MULW-1:0] mul,
  output logic [PHW-1:0]  step
);
  logic [PHW-1:0]  base_ext;
  logic [PHW-1:0]  off_ext;
  logic [PHW-1:0]  d_nx;
  logic [PHW-1:0]  d_q;
  logic [MULW-1:0] mul_q;
  logic [PHW-1:0]  prod;

  always_comb begin
    base_ext = {2'b00, base_in};
    off_ext  = {{(PHW-5){1'b0}}, dt_off};
    d_nx     = base_ext;
    if (dt_en) d_nx = dt_neg ? (base_ext - off_ext) : (base_ext + off_ext);
  end

  // Product kept at PHW bits: the multiply result is truncated by definition.
  assign prod = d_q * {{(PHW-MULW){1'b0}}, mul_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q   <= '0;
      mul_q <= '0;
      step  <= '0;
    end else if (cen) begin
      d_q   <= d_nx;
      mul_q <= mul;
      step  <= (mul_q == '0) ? {1'b0, d_q[PHW-1:1]} : prod;
    end
  end
endmodule

// File: rtl/jt51_pg_acc.sv
// Time-multiplexed phase accumulator: slot counter, per-slot phase store, latency 3 cen cycles.
module jt51_pg_acc
  import jt51_pg_pkg::*;
#(
  parameter int SLOTS = SLOTS_DEF,
  parameter int PHW   = PHW_DEF,
  parameter int OUTW  = OUTW_DEF,
  parameter int MULW  = MULW_DEF
) (
  input logic clk,
  input logic rst,
  jt51_pg_acc_if.slave bus
);
  localparam int SW = $clog2(SLOTS);
  localparam logic [SW-1:0] LAST = SW'(SLOTS - 1);

  logic [SW-1:0]  cnt;
  logic [SW-1:0]  slot_in;
  logic           seen;

  logic [SW-1:0]  s1_slot, s2_slot;
  pg_op_t         s1_op, s2_op;
  logic [PHW-1:0] s1_lv, s2_lv;
  logic           s1_vld, s2_vld;

  logic [PHW-1:0] step;
  logic [PHW-1:0] ph_mem [SLOTS];
  logic [PHW-1:0] ph_cur;
  logic [PHW-1:0] ph_nx;

  jt51_pg_step #(
    .PHW  (PHW),
    .MULW (MULW)
  ) u_step (
    .clk     (clk),
    .rst     (rst),
    .cen     (bus.cen),
    .base_in (bus.base_in),
    .dt_off  (bus.dt_off),
    .dt_en   (bus.dt_en),
    .dt_neg  (bus.dt_neg),
    .mul     (bus.mul),
    .step    (step)
  );

  // cnt holds the slot of the sample currently on the inputs; zero overrides it.
  assign slot_in = bus.zero ? '0 : cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      seen    <= 1'b0;
      s1_slot <= '0;
      s1_op   <= OP_ADD;
      s1_lv   <= '0;
      s1_vld  <= 1'b0;
      s2_slot <= '0;
      s2_op   <= OP_ADD;
      s2_lv   <= '0;
      s2_vld  <= 1'b0;
    end else if (bus.cen) begin
      cnt     <= (slot_in == LAST) ? '0 : slot_in + 1'b1;
      seen    <= seen | bus.zero;
      s1_slot <= slot_in;
      s1_op   <= pg_op(bus.pg_rst, bus.load, bus.hold);
      s1_lv   <= bus.load_val;
      s1_vld  <= seen | bus.zero;
      s2_slot <= s1_slot;
      s2_op   <= s1_op;
      s2_lv   <= s1_lv;
      s2_vld  <= s1_vld;
    end
  end

  assign ph_cur = ph_mem[s2_slot];

  always_comb begin
    ph_nx = ph_cur + step;
    case (s2_op)
      OP_CLR:  ph_nx = '0;
      OP_LOAD: ph_nx = s2_lv;
      OP_HOLD: ph_nx = ph_cur;
      default: ph_nx = ph_cur + step;
    endcase
  end

  // Each slot is revisited only every SLOTS samples, so read and write-back never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) ph_mem[i] <= '0;
      bus.phase_out <= '0;
      bus.step_out  <= '0;
      bus.slot_out  <= '0;
      bus.valid     <= 1'b0;
    end else if (bus.cen) begin
      ph_mem[s2_slot] <= ph_nx;
      bus.phase_out   <= ph_nx[PHW-1 -: OUTW];
      bus.step_out    <= step;
      bus.slot_out    <= s2_slot;
      bus.valid       <= bus.valid | s2_vld;
    end
  end
endmodule

// File: tb/tb_jt51_pg_acc.sv
// Scoreboard bench: a behavioural model queues expected outputs per sample, compared 3 cen cycles later.
module tb_jt51_pg_acc;
  localparam int SLOTS = 32;
  localparam int PHW   = 20;
  localparam int OUTW  = 10;
  localparam int MASK  = (1 << PHW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  jt51_pg_acc_if bus ();
  jt51_pg_acc_if #(.SLOTS(24)) b24 ();

  jt51_pg_acc dut (.clk(clk), .rst(rst), .bus(bus));
  jt51_pg_acc #(.SLOTS(24)) dut24 (.clk(clk), .rst(rst), .bus(b24));

  typedef struct { int slot; int step; int ph; bit vld; } exp_t;
  typedef struct { int base; int off; bit en; bit neg; int mul; int step; } vec_t;

  exp_t q[$];
  int   q24[$];
  int   checks = 0;
  int   failures = 0;

  int   model_ph [SLOTS];
  int   tb_cnt = 0;
  bit   seen = 0;
  int   c24 = 0;
  int   base_a [SLOTS], off_a [SLOTS], mul_a [SLOTS];
  bit   en_a [SLOTS], neg_a [SLOTS];
  vec_t tab [8];

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endfunction

  function automatic void push_bubbles();
    exp_t e;
    e = '{0, 0, 0, 1'b0};
    q.push_back(e);
    q.push_back(e);
    q24.push_back(0);
    q24.push_back(0);
  endfunction

  task automatic compare_front();
    exp_t e;
    if (q.size() >= 3) begin
      e = q.pop_front();
      chk("slot_out", bus.slot_out, e.slot);
      chk("step_out", bus.step_out, e.step);
      chk("phase_out", bus.phase_out, e.ph);
      chk("valid", bus.valid, e.vld);
    end
  endtask

  task automatic drive(input bit z, input int base, input int off, input bit en, input bit neg,
                       input int mul, input bit pr, input bit hd, input bit ld, input int lv,
                       input int xstep, input int xph);
    int s, d, st, p;
    exp_t e;
    s = z ? 0 : tb_cnt;
    tb_cnt = (s + 1) % SLOTS;
    d = base;
    if (en) d = neg ? base - off : base + off;
    d = d & MASK;
    st = (mul == 0) ? (d >> 1) : ((d * mul) & MASK);
    if (xstep >= 0) st = xstep;
    p = pr ? 0 : ld ? lv : hd ? model_ph[s] : ((model_ph[s] + st) & MASK);
    if (xph >= 0) p = xph;
    model_ph[s] = p;
    seen = seen | z;
    e = '{s, st, p >> (PHW - OUTW), seen};
    q.push_back(e);
    bus.cen = 1'b1;      bus.zero = z;
    bus.base_in = 18'(base);  bus.dt_off = 5'(off);
    bus.dt_en = en;      bus.dt_neg = neg;    bus.mul = 4'(mul);
    bus.pg_rst = pr;     bus.hold = hd;       bus.load = ld;
    bus.load_val = 20'(lv);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic step1(input bit z);
    int s;
    s = z ? 0 : tb_cnt;
    drive(z, base_a[s], off_a[s], en_a[s], neg_a[s], mul_a[s], 0, 0, 0, 0, -1, -1);
  endtask

  task automatic free_run(input int n);
    for (int i = 0; i < n; i++) step1(1'b0);
  endtask

  task automatic goto_slot(input int s);
    while (tb_cnt != s) step1(1'b0);
  endtask

  task automatic d24(input bit z);
    int s;
    s = z ? 0 : c24;
    c24 = (s + 1) % 24;
    q24.push_back(s);
    b24.cen = 1'b1;
    b24.zero = z;
    @(posedge clk);
    #1;
    if (q24.size() >= 3) chk("slot24", b24.slot_out, q24.pop_front());
  endtask

  initial begin
    int ph_s, st_s, sl_s;
    bit vl_s;

    bus.cen = 0; bus.zero = 0; bus.base_in = '0; bus.dt_off = '0; bus.dt_en = 0;
    bus.dt_neg = 0; bus.mul = '0; bus.pg_rst = 0; bus.hold = 0; bus.load = 0; bus.load_val = '0;
    b24.cen = 0; b24.zero = 0; b24.base_in = '0; b24.dt_off = '0; b24.dt_en = 0;
    b24.dt_neg = 0; b24.mul = '0; b24.pg_rst = 0; b24.hold = 0; b24.load = 0; b24.load_val = '0;

    tab[0] = '{1000,     8, 1, 1, 0, 496};
    tab[1] = '{1000,     8, 1, 0, 3, 3024};
    tab[2] = '{1000,     0, 0, 0, 1, 1000};
    tab[3] = '{0,        1, 1, 1, 1, 'hFFFFF};
    tab[4] = '{'h3FFFF, 31, 1, 0, 15, 'hC01C2};
    tab[5] = '{5,        0, 0, 0, 0, 2};
    tab[6] = '{100,     31, 1, 1, 2, 138};
    tab[7] = '{'h20000,  0, 0, 0, 8, 0};

    for (int i = 0; i < SLOTS; i++) begin
      model_ph[i] = 0;
      base_a[i] = $urandom_range(0, (1 << 18) - 1);
      off_a[i]  = $urandom_range(0, 31);
      en_a[i]   = 1'($urandom_range(0, 1));
      neg_a[i]  = 1'($urandom_range(0, 1));
      mul_a[i]  = $urandom_range(0, 15);
    end
    base_a[5] = 1000; mul_a[5] = 1; en_a[5] = 0;

    #1 rst = 1'b1;
    #2;
    chk("rst_phase_out", bus.phase_out, 0);
    chk("rst_step_out", bus.step_out, 0);
    chk("rst_slot_out", bus.slot_out, 0);
    chk("rst_valid", bus.valid, 0);
    #19 rst = 1'b0;
    push_bubbles();

    // 24-slot instance: wrap at 23, then resync at counter 10
    @(posedge clk); #1;
    d24(1'b1);
    for (int i = 0; i < 47; i++) d24(1'b0);
    while (c24 != 10) d24(1'b0);
    d24(1'b1);
    for (int i = 0; i < 30; i++) d24(1'b0);
    b24.cen = 1'b0;

    // free-run before any zero: valid must stay low
    free_run(3);
    step1(1'b1);
    free_run(70);

    for (int i = 0; i < 8; i++)
      drive(0, tab[i].base, tab[i].off, tab[i].en, tab[i].neg, tab[i].mul,
            0, 0, 0, 0, tab[i].step, -1);

    for (int k = 0; k < 3; k++) begin
      goto_slot(5);
      drive(0, 1000, 0, 0, 0, 1, 0, 0, 0, 0, 1000, -1);
    end

    goto_slot(9);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1, 'hFFF00, -1, 'hFFF00);
    goto_slot(9);
    drive(0, 'h200, 0, 0, 0, 1, 0, 0, 0, 0, 'h200, 'h00100);

    goto_slot(7);
    drive(0, 1000, 0, 0, 0, 1, 1, 0, 1, 'h80000, -1, 0);
    goto_slot(7);
    drive(0, 1000, 0, 0, 0, 1, 0, 0, 1, 'h80000, -1, 'h80000);
    goto_slot(7);
    drive(0, 1000, 0, 0, 0, 1, 0, 1, 0, 0, -1, 'h80000);

    goto_slot(13);
    step1(1'b1);
    free_run(40);

    // cen low: outputs and internal state must not move
    ph_s = bus.phase_out; st_s = bus.step_out; sl_s = bus.slot_out; vl_s = bus.valid;
    bus.cen = 1'b0; bus.zero = 1'b1; bus.pg_rst = 1'b1; bus.load = 1'b1; bus.load_val = 20'h12345;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("frz_phase_out", bus.phase_out, ph_s);
      chk("frz_step_out", bus.step_out, st_s);
      chk("frz_slot_out", bus.slot_out, sl_s);
      chk("frz_valid", bus.valid, vl_s);
    end
    free_run(40);

    // mid-stream reset
    rst = 1'b1;
    #2;
    chk("mrst_phase_out", bus.phase_out, 0);
    chk("mrst_step_out", bus.step_out, 0);
    chk("mrst_slot_out", bus.slot_out, 0);
    chk("mrst_valid", bus.valid, 0);
    chk("mrst_slot24", b24.slot_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < SLOTS; i++) model_ph[i] = 0;
    tb_cnt = 0;
    seen = 0;
    q.delete();
    q24.delete();
    push_bubbles();
    free_run(6);
    step1(1'b1);
    free_run(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
